// File: rtl/instruction_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_encoder: packs five-field ISA tuples into 32-bit words, queues |
// | them and streams them with sequential addresses. Option: ENC_RANGE_CHECK_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_encoder #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_shamt,
    input  logic [4:0]            in_aluop,
    input  logic [31:0]           in_imm,
    input  logic [26:0]           in_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err_illegal,
    output logic                  err_range
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    localparam logic [4:0] c_OP_R    = 5'b00000;
    localparam logic [4:0] c_OP_ADDI = 5'b00101;
    localparam logic [4:0] c_OP_SW   = 5'b00111;
    localparam logic [4:0] c_OP_LW   = 5'b01000;
    localparam logic [4:0] c_OP_BNE  = 5'b00010;
    localparam logic [4:0] c_OP_BLT  = 5'b00110;
    localparam logic [4:0] c_OP_J    = 5'b00001;
    localparam logic [4:0] c_OP_JAL  = 5'b00011;
    localparam logic [4:0] c_OP_SETX = 5'b10101;
    localparam logic [4:0] c_OP_BEX  = 5'b10110;
    localparam logic [4:0] c_OP_JR   = 5'b00100;

    logic [31:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_err_illegal;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_is_itype;
    logic        w_range_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // Unused fields of each format stay zero because w_word defaults to zero.
    always_comb begin
        w_word     = '0;
        w_legal    = 1'b1;
        w_is_itype = 1'b0;
        case (in_opcode)
            c_OP_R: begin
                w_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            end
            c_OP_ADDI, c_OP_SW, c_OP_LW, c_OP_BNE, c_OP_BLT: begin
                w_is_itype = 1'b1;
                w_word     = {in_opcode, in_rd, in_rs, in_imm[16:0]};
            end
            c_OP_J, c_OP_JAL, c_OP_SETX, c_OP_BEX: begin
                w_word = {in_opcode, in_target};
            end
            c_OP_JR: begin
                w_word = {in_opcode, in_rd, 22'd0};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_head];
    assign out_addr  = r_addr;
    assign err_illegal = r_err_illegal;

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & w_legal & w_range_ok;
    assign w_pop    = out_valid & out_ready;

`ifdef ENC_RANGE_CHECK_EN
    logic r_err_range;
    logic w_in_range;

    // Immediate fits in 17 signed bits when the upper 16 bits are a pure sign extension.
    assign w_in_range = (in_imm[31:16] == 16'h0000) || (in_imm[31:16] == 16'hFFFF);
    assign w_range_ok = ~w_is_itype | w_in_range;
    assign err_range  = r_err_range;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_err_range <= 1'b0;
        end else if (w_accept && w_legal && !w_range_ok) begin
            r_err_range <= 1'b1;
        end
    end
`else
    logic w_unused_range_inputs;

    assign w_range_ok            = 1'b1;
    assign err_range             = 1'b0;
    assign w_unused_range_inputs = ^{w_is_itype, in_imm[31:17]};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_addr        <= BASE_ADDR;
            r_err_illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_addr        <= BASE_ADDR;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_word;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_legal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_encoder: scoreboard bench for instruction_encoder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instruction_encoder;

    localparam int AW = 12;

    typedef struct packed {
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_shamt = '0;
    logic [4:0]    in_aluop = '0;
    logic [31:0]   in_imm = '0;
    logic [26:0]   in_target = '0;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          err_illegal;
    logic          err_range;

    logic ready_manual = 1'b0;
    logic ready_rand   = 1'b0;
    logic rand_mode    = 1'b0;
    assign out_ready = rand_mode ? ready_rand : ready_manual;

    exp_t          sb[$];
    logic [AW-1:0] next_addr = '0;
    int            checks = 0;
    int            passed = 0;
    int            cyc = 0;
    int            last_pop_cyc = 0;

    always #5 clock = ~clock;

    instruction_encoder #(.DEPTH(4), .ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_range(err_range)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (rand_mode) begin
            #1;
            ready_rand = 1'($urandom_range(0, 1));
        end
    end

    // Every word the DUT hands over is compared against the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            last_pop_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word: data=%h addr=%h, none expected", out_data, out_addr);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_addr !== e.addr)
                    $display("FAIL word: data=%h addr=%h, required data=%h addr=%h",
                             out_data, out_addr, e.data, e.addr);
                else
                    passed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_model(input logic [4:0] op, rd, rs, rt, sh, alu,
                                              input logic [31:0] imm, input logic [26:0] tgt,
                                              output bit legal);
        legal = 1'b1;
        case (op)
            5'b00000: return {op, rd, rs, rt, sh, alu, 2'b00};
            5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: return {op, rd, rs, imm[16:0]};
            5'b00001, 5'b00011, 5'b10101, 5'b10110: return {op, tgt};
            5'b00100: return {op, rd, 22'd0};
            default: begin
                legal = 1'b0;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] op, rd, rs, rt, sh, alu,
                        input logic [31:0] imm, input logic [26:0] tgt,
                        input bit push, input logic [31:0] word);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            passed++;
            tick();
            if (push) begin
                sb.push_back({word, next_addr});
                next_addr = next_addr + 1'b1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        next_addr = '0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        checks++;
        if (!done)
            $display("FAIL drain: pending=%0d out_valid=%b, required 0 and 0", sb.size(), out_valid);
        else
            passed++;
        tick();
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        flush = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        next_addr = '0;
        checks += 6;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: %b, required 1", in_ready); else passed++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: %b, required 0", out_valid); else passed++;
        if (out_data !== 32'd0) $display("FAIL rst_out_data: %h, required 0", out_data); else passed++;
        if (out_addr !== 12'd0) $display("FAIL rst_out_addr: %h, required 0", out_addr); else passed++;
        if (err_illegal !== 1'b0) $display("FAIL rst_err_illegal: %b, required 0", err_illegal); else passed++;
        if (err_range !== 1'b0) $display("FAIL rst_err_range: %b, required 0", err_range); else passed++;
    endtask

    task automatic test_addi();
        do_flush();
        ready_manual = 1'b1;
        send(5'b00101, 5'd3, 5'd1, 5'd7, 5'd9, 5'd11, -32'sd1, 27'h7FFFFFF, 1'b1, 32'h28C3FFFF);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL addi_latency: out_valid=%b, required 1", out_valid);
        else passed++;
        wait_drain();
    endtask

    task automatic test_add_j();
        do_flush();
        ready_manual = 1'b1;
        send(5'b00000, 5'd4, 5'd2, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 27'h5555555, 1'b1, 32'h01043000);
        send(5'b00001, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 32'h12345678, 27'h0000123, 1'b1, 32'h08000123);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int c0;
        do_flush();
        ready_manual = 1'b0;
        for (int i = 0; i < 4; i++)
            send(5'b00101, 5'(i), 5'(i), 5'd0, 5'd0, 5'd0, 32'(i), 27'd0, 1'b1,
                 {5'b00101, 5'(i), 5'(i), 17'(i)});
        checks++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready: %b, required 0", in_ready); else passed++;
        idle();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h28000000 || out_addr !== 12'd0)
            $display("FAIL hold_stable: valid=%b data=%h addr=%h, required 1 28000000 000",
                     out_valid, out_data, out_addr);
        else passed++;
        c0 = cyc;
        ready_manual = 1'b1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL no_comb_ready: %b, required 0", in_ready); else passed++;
        send(5'b00101, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 32'd4, 27'd0, 1'b1, 32'h29080004);
        wait_drain();
        checks++;
        if (last_pop_cyc !== c0 + 4)
            $display("FAIL drain_rate: last pop at cycle %0d, required %0d", last_pop_cyc, c0 + 4);
        else passed++;
    endtask

    task automatic test_illegal();
        do_flush();
        ready_manual = 1'b1;
        send(5'b11111, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'd6, 27'd7, 1'b0, 32'd0);
        checks += 2;
        if (err_illegal !== 1'b1) $display("FAIL illegal_flag: %b, required 1", err_illegal); else passed++;
        if (out_valid !== 1'b0) $display("FAIL illegal_no_word: out_valid=%b, required 0", out_valid); else passed++;
        send(5'b00100, 5'd31, 5'd5, 5'd6, 5'd7, 5'd8, 32'hFFFFFFFF, 27'h7FFFFFF, 1'b1, 32'h27C00000);
        wait_drain();
        checks++;
        if (err_illegal !== 1'b1) $display("FAIL illegal_sticky: %b, required 1", err_illegal); else passed++;
    endtask

    task automatic test_range();
        do_flush();
        ready_manual = 1'b1;
`ifdef ENC_RANGE_CHECK_EN
        send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0, 1'b0, 32'd0);
        checks += 2;
        if (err_range !== 1'b1) $display("FAIL range_flag: %b, required 1", err_range); else passed++;
        if (out_valid !== 1'b0) $display("FAIL range_drop: out_valid=%b, required 0", out_valid); else passed++;
        send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, -32'sd65536, 27'd0, 1'b1, 32'h28010000);
        wait_drain();
        checks++;
        if (err_range !== 1'b1) $display("FAIL range_sticky: %b, required 1", err_range); else passed++;
`else
        send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0, 1'b1, 32'h28011170);
        send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, -32'sd65536, 27'd0, 1'b1, 32'h28010000);
        wait_drain();
        checks++;
        if (err_range !== 1'b0) $display("FAIL range_tied: %b, required 0", err_range); else passed++;
`endif
        do_flush();
        checks++;
        if (err_range !== 1'b0) $display("FAIL range_flush: %b, required 0", err_range); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [12] = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110,
                                 5'b00001, 5'b00011, 5'b10101, 5'b10110, 5'b00100, 5'b11110};
        logic [4:0]  op, rd, rs, rt, sh, alu;
        logic [31:0] imm, word;
        logic [26:0] tgt;
        bit          legal;
        do_flush();
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op  = (i == 5) ? 5'b11110 : ops[$urandom_range(0, 11)];
            rd  = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
            sh  = 5'($urandom); alu = 5'($urandom); tgt = 27'($urandom);
            imm = 32'($urandom_range(0, 131071)) - 32'd65536;
            word = enc_model(op, rd, rs, rt, sh, alu, imm, tgt, legal);
            send(op, rd, rs, rt, sh, alu, imm, tgt, legal, word);
        end
        rand_mode = 1'b0;
        ready_manual = 1'b1;
        wait_drain();
        checks++;
        if (err_illegal !== 1'b1) $display("FAIL b2b_illegal: %b, required 1", err_illegal); else passed++;
    endtask

    task automatic test_flush_wrap();
        do_flush();
        ready_manual = 1'b1;
        for (int i = 0; i < 4095; i++)
            send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'(i), 1'b1, {5'b00001, 27'(i)});
        wait_drain();
        ready_manual = 1'b0;
        for (int i = 0; i < 3; i++)
            send(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'(i), 1'b1, {5'b00011, 27'(i)});
        send(5'b01111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0, 1'b0, 32'd0);
        checks += 2;
        if (out_addr !== 12'hFFF) $display("FAIL pre_flush_addr: %h, required FFF", out_addr); else passed++;
        if (err_illegal !== 1'b1) $display("FAIL pre_flush_err: %b, required 1", err_illegal); else passed++;
        do_flush();
        checks += 4;
        if (out_valid !== 1'b0) $display("FAIL flush_valid: %b, required 0", out_valid); else passed++;
        if (out_addr !== 12'h000) $display("FAIL flush_addr: %h, required 000", out_addr); else passed++;
        if (err_illegal !== 1'b0) $display("FAIL flush_err: %b, required 0", err_illegal); else passed++;
        if (in_ready !== 1'b1) $display("FAIL flush_ready: %b, required 1", in_ready); else passed++;
        ready_manual = 1'b1;
        for (int i = 0; i < 4097; i++)
            send(5'b10101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'(i), 1'b1, {5'b10101, 27'(i)});
        wait_drain();
        checks++;
        if (out_addr !== 12'h001) $display("FAIL wrap_addr: %h, required 001", out_addr); else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add_j();
        test_backpressure();
        test_illegal();
        test_range();
        test_back_to_back();
        test_flush_wrap();
        checks++;
        if (sb.size() != 0) $display("FAIL leftover: %0d words pending, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
# instruction_encoder

Packs instruction fields into 32-bit instruction words for the processor's five-field ISA, buffers them, and streams them with sequential addresses to the instruction-memory write port. It is the inverse of the instruction decode path in the processor. The program loader uses it to build test programs and boot images, and the self-check harness uses it to generate reference words from field tuples.

## Interface
Parameters:
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 12: instruction-memory word-address width.
- BASE_ADDR, 0: first address emitted after reset or flush.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of FIFO, address counter and error flags.
- in_valid  in  1  field tuple present.
- in_ready  out  1  encoder can accept a tuple.
- in_opcode  in  5  opcode.
- in_rd, in_rs, in_rt  in  5 each  register fields.
- in_shamt, in_aluop  in  5 each  R-type shift amount and ALU op.
- in_imm  in  32  signed immediate (two's complement).
- in_target  in  27  jump target.
- out_valid  out  1  encoded word available.
- out_ready  in  1  memory side consumes the word.
- out_data  out  32  encoded word (FIFO head).
- out_addr  out  ADDR_WIDTH  word address for out_data.
- err_illegal  out  1  sticky: unknown opcode seen.
- err_range  out  1  sticky: immediate out of range (only with ENC_RANGE_CHECK_EN).

## Operation
- Field packing:
  - opcode[31:27].
  - rd[26:22], rs[21:17], rt[16:12], shamt[11:7], ALUop[6:2], bits[1:0]=0.
  - imm[16:0] = in_imm[16:0].
  - target[26:0].
- Format by opcode:
  - R-type: 00000. Packs rd, rs, rt, shamt, aluop.
  - I-type: 00101 addi, 00111 sw, 01000 lw, 00010 bne, 00110 blt. Packs rd, rs and imm[16:0].
  - JI-type: 00001 j, 00011 jal, 10101 setx, 10110 bex. Packs target[26:0].
  - JII-type: 00100 jr. Packs rd; bits[21:0]=0.
  - Fields not used by the selected format are forced to zero regardless of input.
- Any other opcode: the tuple is accepted (handshake completes), no word is written, and err_illegal is set.
- Accepted, legal tuple: the encoded word is pushed into the FIFO on the accepting edge.
- FIFO: circular buffer with head/tail pointers and count of width log2(DEPTH)+1.
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[head].
- Address counter:
  - Starts at BASE_ADDR.
  - Increments by 1 on each pop (out_valid & out_ready).
  - Wraps modulo 2^ADDR_WIDTH with no flag.
  - Dropped tuples do not consume an address.
- Simultaneous push and pop: count unchanged; both pointers advance. Allowed whenever count is between 1 and DEPTH-1, and also at count==DEPTH-1.
- flush: count=0, pointers=0, address=BASE_ADDR, both error flags cleared. A push or pop in the same cycle is ignored.
- reset: same effect as flush; additionally all FIFO storage and out_data read 0. Reset has priority over flush.
- Reset or flush mid-stream discards queued words without emitting them.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_addr=BASE_ADDR, err_illegal=0, err_range=0.
- Latency: a tuple accepted at edge N produces out_valid=1 after edge N. There is no combinational in→out bypass.
- Throughput: one tuple per cycle while not full; one word per cycle while not empty.
- Full FIFO: in_ready=0. A pop in the same cycle does not raise in_ready combinationally; in_ready rises after the pop edge.
- out_data and out_addr hold stable while out_valid=1 and out_ready=0.
- Error flags are set on the accepting edge and remain set until reset or flush.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - For I-type tuples, in_imm must satisfy −65536 ≤ in_imm ≤ 65535, i.e. in_imm[31:16] all equal.
  - Otherwise the tuple is dropped (no push, no address consumed) and err_range is set.
- ENC_RANGE_CHECK_EN undefined:
  - in_imm is truncated to [16:0] silently.
  - err_range is tied to 0.

## Test plan
- addi: opcode 00101, rd=3, rs=1, imm=−1 → out_data=0x28C3FFFF, out_addr=0, out_valid=1 one cycle after accept.
- add and j:
  - R-type add rd=4, rs=2, rt=3, shamt=0, aluop=0 → 0x01043000.
  - j target=0x0000123 → 0x08000123.
  - Consecutive addresses 0 and 1.
- Backpressure: hold out_ready=0 and push 5 tuples with DEPTH=4.
  - Expect in_ready=0 after the 4th accept.
  - Release out_ready; expect words in order with addresses 0..3 and one word per cycle.
  - The 5th tuple is accepted once space frees.
- Illegal opcode 11111 followed by a legal jr rd=31 → err_illegal=1; only 0x27C00000 is emitted, at address 0.
- Range check: with ENC_RANGE_CHECK_EN, addi imm=70000 → dropped and err_range=1; without it, out_data[16:0]=70000 mod 2^17.
- Flush while holding 3 words with out_addr=0xFFF (ADDR_WIDTH=12) → out_valid=0 next cycle, out_addr=BASE_ADDR, flags clear. Separately, a pop at 0xFFF wraps out_addr to 0x000.
